// File: rtl/filter_pkg.sv
// Shared definitions for the 5x5 filter-window interface and its kernels.
package filter_pkg;
  localparam int KERNEL = 5;
  localparam int PIX_W  = 8;
  localparam int WIN_W  = KERNEL * KERNEL * PIX_W;

  // Bit offset of window element (r,c); r = row (0 = oldest), c = column.
  function automatic int win_idx(input int r, input int c, input int pw = PIX_W);
    return (KERNEL * r + c) * pw;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One-row pixel delay: circular RAM with read-before-write at the shared pointer.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;

  // Pointer advance, wrapping at DEPTH-1.
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      if (ptr_q == AW'(DEPTH - 1)) begin
        ptr_d = {AW{1'b0}};
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= {AW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage write; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

  assign dout = mem[ptr_q];
endmodule

// File: rtl/window_gen_5x5.sv
// Raster pixel stream to 5x5 window converter; emits only windows fully inside the image.
module window_gen_5x5 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = filter_pkg::PIX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     pix_in,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  output logic                 pix_ready,
  output logic [25*PIX_W-1:0]  win_out,
  output logic                 win_valid,
  output logic                 win_last,
  input  logic                 win_ready
);
  import filter_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int WW = KERNEL * KERNEL * PIX_W;

  logic [CW-1:0]    col_q, col_d, cur_col_s;
  logic [RW-1:0]    row_q, row_d, cur_row_s;
  logic [WW-1:0]    win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             accept_s, emit_s, last_pix_s;
  logic [PIX_W-1:0] lb_in  [4];
  logic [PIX_W-1:0] lb_out [4];
  logic [PIX_W-1:0] col4_s [KERNEL];

  assign pix_ready = !win_valid_q || win_ready;
  assign accept_s  = pix_valid && pix_ready;

  // Four chained row delays: lb_out[i] is the pixel i+1 rows above pix_in.
  assign lb_in[0] = pix_in;
  for (genvar i = 0; i < 4; i++) begin : g_lb
    if (i > 0) begin : g_chain
      assign lb_in[i] = lb_out[i-1];
    end
    line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (accept_s),
      .din  (lb_in[i]),
      .dout (lb_out[i])
    );
  end

  // Position of the pixel being offered; pix_sof forces it to (0,0).
  always_comb begin
    if (pix_sof) begin
      cur_col_s = {CW{1'b0}};
      cur_row_s = {RW{1'b0}};
    end else begin
      cur_col_s = col_q;
      cur_row_s = row_q;
    end
    emit_s     = accept_s && (cur_row_s >= RW'(4)) && (cur_col_s >= CW'(4));
    last_pix_s = (cur_row_s == RW'(IMG_HEIGHT - 1)) && (cur_col_s == CW'(IMG_WIDTH - 1));
  end

  // Raster counters.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_s) begin
      if (cur_col_s == CW'(IMG_WIDTH - 1)) begin
        col_d = {CW{1'b0}};
        if (cur_row_s == RW'(IMG_HEIGHT - 1)) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = cur_row_s + RW'(1);
        end
      end else begin
        col_d = cur_col_s + CW'(1);
        row_d = cur_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Window shift: columns move left, the new column enters at c=4 (oldest row at r=0).
  always_comb begin
    for (int r = 0; r < KERNEL; r++) begin
      col4_s[r] = (r == KERNEL - 1) ? pix_in : lb_out[3 - r];
    end
    win_d = win_q;
    if (accept_s) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          if (c < KERNEL - 1) begin
            win_d[win_idx(r, c, PIX_W) +: PIX_W] = win_q[win_idx(r, c + 1, PIX_W) +: PIX_W];
          end else begin
            win_d[win_idx(r, c, PIX_W) +: PIX_W] = col4_s[r];
          end
        end
      end
    end else begin
      win_d = win_q;
    end
  end

  // Output flags: a fresh window wins over a completed handshake; otherwise hold.
  always_comb begin
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    if (emit_s) begin
      win_valid_d = 1'b1;
      win_last_d  = last_pix_s;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
      win_last_d  = win_last_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      win_q       <= {WW{1'b0}};
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_out   = win_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
endmodule

// File: doc/window_gen_5x5.md
Name: window_gen_5x5

Overview:
- Producer end of the 5x5 filter-window interface: converts a raster-order 8-bit pixel stream into 200-bit 5x5 windows for the Sobel/edge filter kernels.
- Sits between the decoded-pixel stream (post colour conversion) and the filter bank.
- Holds four previous image rows in line buffers plus a 5x5 shift register.
- Emits only windows lying fully inside the image, giving (IMG_WIDTH-4) x (IMG_HEIGHT-4) windows per frame.

Parameters:
- IMG_WIDTH, 640, pixels per row; must be at least 5.
- IMG_HEIGHT, 480, rows per frame; must be at least 5.
- PIX_W, 8, bits per pixel. The window width is 25*PIX_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_in  in  PIX_W  input pixel, raster order
- pix_valid  in  1  pix_in valid
- pix_sof  in  1  start of frame; qualifies the pixel at (0,0)
- pix_ready  out  1  block can accept a pixel this cycle
- win_out  out  25*PIX_W  5x5 window
- win_valid  out  1  win_out valid
- win_last  out  1  last window of the frame
- win_ready  in  1  downstream accepts the window

Behaviour:
- **Reset:** one clock, rst synchronous active-high. On rst:
  - win_valid=0, win_last=0, win_out=0.
  - Column and row counters = 0; window shift register = 0.
  - Line-buffer contents need not be cleared.
  - pix_ready is 1 in the cycle after reset is released.
- **Input handshake:**
  - A pixel is accepted when pix_valid && pix_ready.
  - pix_ready = !win_valid || win_ready. This is combinational and there is no skid buffer.
- **Counters:**
  - col advances on each accepted pixel. At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At row IMG_HEIGHT-1, col IMG_WIDTH-1, both counters wrap to 0 and the next frame begins.
- **pix_sof:**
  - An accepted pixel with pix_sof=1 is treated as (0,0) regardless of the counters. Counters then continue from (0,1).
  - pix_sof on an unaccepted cycle is ignored.
- **Line buffers:**
  - Four chained one-row delays, each IMG_WIDTH deep.
  - On each accepted pixel, each buffer shifts by one.
  - The window column shifts left by one and column 4 loads {lb3_out, lb2_out, lb1_out, lb0_out, pix_in} for rows 0..4.
- **Window layout:**
  - Element (r,c), with r = row and c = column and r,c in 0..4, is at bits [(5r+c)*PIX_W +: PIX_W].
  - Element (r,c) holds pixel (row-4+r, col-4+c) of the accepted pixel at (row,col).
  - So r=0 is the top (oldest) row, win_out[PIX_W-1:0] is the top-left pixel, and the top bits hold the newly accepted pixel.
- **Emission and latency:**
  - Accepting a pixel with row>=4 and col>=4 sets win_valid=1 on the next clock edge, with win_out holding that window. Latency is one cycle.
  - win_last=1 only when that pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Windows that would straddle a row boundary (col<4) or lie in rows 0..3 are never emitted.
- **Output hold:** while win_valid && !win_ready, win_out, win_valid and win_last are held stable and no pixel is accepted.
- **Output clear:** win_valid clears after a handshake unless a new window is produced in the same cycle. Back-to-back throughput is 1 window/cycle.
- **Frame wrap:** no cross-frame mixing. Rows 0..3 of the new frame emit nothing, and by row 4 the line buffers hold only new-frame data.
- **Reset mid-frame:** partial window discarded, counters return to (0,0), and the next pixel is treated as (0,0).

Decomposition:
- Shared package filter_pkg holds:
  - KERNEL = 5
  - PIX_W default
  - WIN_W = KERNEL*KERNEL*PIX_W
  - function win_idx(r,c) returning the bit offset (5r+c)*PIX_W
- The filter kernels use the same package.
- One sub-module: line_buffer, a parameterised DEPTH x PIX_W one-row delay with shift enable. It uses a circular RAM pointer, with read-before-write at the same address. It is instantiated 4 times in a chain.

Test Plan:
- **Basic frame:** IMG_WIDTH=8, IMG_HEIGHT=6, pixel = row*16+col, win_ready=1, pix_valid continuous.
  - Exactly 8 windows are produced.
  - First window: bits [7:0]=0x00 and bits [199:192]=0x44.
  - Last window: win_last=1, bits [7:0]=0x13, bits [199:192]=0x57.
- **Backpressure:** drop win_ready for 3 cycles while win_valid=1.
  - win_out and win_valid are stable and pix_ready=0.
  - After release, the full sequence of 8 windows is intact and in order.
- **Bursty input:** random pix_valid gaps at about 50%. Window contents are identical to the basic-frame case.
- **Back-to-back frames:** two frames, the second with pixel = 0x80+row*16+col.
  - 16 windows are produced, 2 with win_last.
  - Every frame-2 window has all bytes >= 0x80.
- **Reset mid-frame:** assert rst after 20 pixels.
  - win_valid=0 the next cycle.
  - A restarted full frame yields exactly 8 correct windows.
- **pix_sof resync:** assert pix_sof on the 3rd pixel of the stream, treating it as (0,0). Exactly 8 windows follow, aligned to that pixel.
